pc_predict_unit: RTL

Parametrised next-generation fetch PC unit for the pipelined core. It combines the PC register and next-PC selection with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It predicts taken branches and jumps in fetch, and takes resolution information from the Execute stage. It detects mispredictions, redirects fetch, and flags the flush for the F/D and D/E pipeline registers.

---
 rtl/pc_predict_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_predict_unit.sv
// Fetch PC unit: PC register, next-PC selection, direct-mapped BTB with 2-bit direction counters,
// Execute-stage misprediction detection and redirect.
module pc_predict_unit #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCen_i,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] PCPlus4F_o,
  output logic                  PredTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o,
  input  logic                  ResolveE_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic                  TakenE_i,
  input  logic [DATA_WIDTH-1:0] TargetE_i,
  input  logic                  PredTakenE_i,
  input  logic [DATA_WIDTH-1:0] PredTargetE_i,
  output logic                  MispredictE_o,
  output logic [CNT_WIDTH-1:0]  MispredCount_o
);

  localparam int unsigned Idx  = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW = DATA_WIDTH - Idx - 2;

  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TagW-1:0]        tag_q    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [Idx-1:0]         f_idx, e_idx;
  logic [TagW-1:0]        f_tag, e_tag;
  logic                   hit_f, hit_e;
  logic [DATA_WIDTH-1:0]  pc_plus4, redirect_pc;
  logic                   mispredict;
  logic                   btb_we;
  logic [1:0]             new_ctr;

  assign f_idx = pc_q[Idx+1:2];
  assign f_tag = pc_q[DATA_WIDTH-1:Idx+2];
  assign e_idx = PCE_i[Idx+1:2];
  assign e_tag = PCE_i[DATA_WIDTH-1:Idx+2];

  assign hit_f    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign hit_e    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  assign mispredict = ResolveE_i &
                      ((TakenE_i != PredTakenE_i) |
                       (TakenE_i & PredTakenE_i & (TargetE_i != PredTargetE_i)));
  assign redirect_pc = TakenE_i ? TargetE_i : (PCE_i + DATA_WIDTH'(4));

  assign PCF_o          = pc_q;
  assign PCPlus4F_o     = pc_plus4;
  assign PredTakenF_o   = hit_f & ctr_q[f_idx][1];
  assign PredTargetF_o  = hit_f ? target_q[f_idx] : pc_plus4;
  assign MispredictE_o  = mispredict;
  assign MispredCount_o = cnt_q;

  // A redirect from Execute overrides a fetch stall.
  always_comb begin
    pc_d = pc_plus4;
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (!PCen_i) begin
      pc_d = pc_q;
    end else if (PredTakenF_o) begin
      pc_d = PredTargetF_o;
    end
  end

  assign cnt_d = mispredict ? (cnt_q + CNT_WIDTH'(1)) : cnt_q;

  always_comb begin
    btb_we  = 1'b0;
    new_ctr = ctr_q[e_idx];
    if (ResolveE_i) begin
      if (hit_e) begin
        btb_we = 1'b1;
        if (TakenE_i) begin
          new_ctr = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'b01;
        end else begin
          new_ctr = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'b01;
        end
      end else if (TakenE_i) begin
        btb_we  = 1'b1;
        new_ctr = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (btb_we) begin
      valid_q[e_idx] <= 1'b1;
      tag_q[e_idx]   <= e_tag;
      ctr_q[e_idx]   <= new_ctr;
      // A not-taken hit keeps the stored target.
      if (TakenE_i) begin
        target_q[e_idx] <= TargetE_i;
      end
    end
  end

endmodule
